sub16_seq: RTL and testbench
============================

SUB16_SEQ -- requirements
Module: sub16_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; SHALL be a multiple of 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 x  input  WIDTH  minuend, sampled with accepted start.
REQ-006 y  input  WIDTH  subtrahend, sampled with accepted start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse; z and flags valid from this cycle.
REQ-009 z  output  WIDTH  difference x-y modulo 2^WIDTH.
REQ-010 sign, zero, borrow, parity, overflow  output  1 each  result flags.

Function
REQ-011 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-012 IDLE: start=1 at an edge -> latch x, y; clear nibble index and borrow-in to 0; go to RUN.
REQ-013 RUN: each edge computes one 4-bit slice, LSB nibble first: diff = x_nib - y_nib - bin; store nibble into z; borrow-out registered as next bin.
REQ-014 RUN SHALL last exactly WIDTH/4 cycles; after the last nibble, go to DONE.
REQ-015 Latency: start sampled at edge k -> done=1 in the cycle after edge k+WIDTH/4 (4 cycles for WIDTH=16).
REQ-016 DONE lasts one cycle, done=1, then IDLE; start sampled in DONE SHALL be accepted (back-to-back, no idle gap).
REQ-017 busy=1 in RUN only; busy SHALL be 0 in IDLE and DONE.
REQ-018 start while busy=1 SHALL be ignored; latched operands are unaffected.
REQ-019 x, y changes after acceptance SHALL NOT affect the result.
REQ-020 Flags registered at the DONE transition, from the final z: sign=z[MSB]; zero=1 iff z==0; parity=XNOR of all z bits (1 = even number of ones).
REQ-021 borrow = final borrow-out = 1 iff x<y unsigned.
REQ-022 overflow = (x[MSB] & ~y[MSB] & ~z[MSB]) | (~x[MSB] & y[MSB] & z[MSB]).
REQ-023 z and flags SHALL hold their values from DONE until the next accepted start's DONE.
REQ-024 z and flags SHALL NOT change while in RUN; partial nibbles go to an internal register.

Reset
REQ-025 rst=1 at an edge: state IDLE; busy=0, done=0, z=0, all flags 0 (including zero), internal registers 0.
REQ-026 rst SHALL take priority over start and abort any operation in RUN; no done pulse is produced for the aborted operation.
REQ-027 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-028 Shared package SHALL hold FSM state typedef (IDLE/RUN/DONE) and constant SLICE_W=4.
REQ-029 One sub-module, sub4: combinational 4-bit slice, inputs a[3:0], b[3:0], bin; outputs d[3:0], bout; instantiated once and reused each RUN cycle.
REQ-030 No other sub-modules.

Verification
REQ-031 x=0x0005, y=0x0003 -> after 4 cycles done=1, z=0x0002, sign=0, zero=0, borrow=0, parity=0, overflow=0.
REQ-032 x=0x0003, y=0x0005 -> z=0xFFFE, sign=1, borrow=1, parity=0, overflow=0, zero=0.
REQ-033 x=0x8000, y=0x0001 -> z=0x7FFF, overflow=1, sign=0, borrow=0, parity=0; x=0x1000, y=0x0001 -> z=0x0FFF (borrow ripples across 3 nibbles).
REQ-034 x=0x1234, y=0x1234 -> z=0x0000, zero=1, parity=1, borrow=0, overflow=0.
REQ-035 Second start with different operands during RUN -> ignored, first result delivered unchanged; start held high in the DONE cycle -> new operation accepted, next done exactly 4 cycles later.
REQ-036 rst=1 during the 2nd RUN cycle -> next cycle busy=0, z=0, all flags 0, no done pulse; the following start completes normally.

Source files
------------

// File: rtl/sub16_seq_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//   state_e  : controller states (IDLE / RUN / DONE)
//   SLICE_W  : width of the slice handled per RUN cycle
package sub16_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub16_seq_if.sv
// Request/result bundle of the nibble-serial subtractor.
//   master : drives start, x, y; observes busy, done, z and flags
//   slave  : the subtractor side
interface sub16_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             sign;
  logic             zero;
  logic             borrow;
  logic             parity;
  logic             overflow;

  modport master (
    output start, x, y,
    input  busy, done, z, sign, zero, borrow, parity, overflow
  );

  modport slave (
    input  start, x, y,
    output busy, done, z, sign, zero, borrow, parity, overflow
  );

endinterface

// File: rtl/sub16_seq_sub4.sv
// Combinational 4-bit subtract slice: d = a - b - bin, bout = borrow out.
//   a, b : slice operands
//   bin  : borrow in
//   d    : slice difference
//   bout : 1 when a - b - bin is negative
module sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] diff;

  // Sign bit of the 5-bit two's-complement result is the borrow.
  assign diff = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
  assign d    = diff[3:0];
  assign bout = diff[4];

endmodule

// File: rtl/sub16_seq.sv
// Nibble-serial subtractor: z = x - y mod 2^WIDTH, one 4-bit slice per cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any operation
//   bus  : slave side of sub16_seq_if (start/x/y in; busy/done/z/flags out)
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one slice per cycle, LSB nibble first, WIDTH/4 cycles
//   DONE  | one-cycle done pulse; start here is accepted directly
module sub16_seq
  import sub16_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  sub16_seq_if.slave  bus
);

  localparam int NIB   = WIDTH / SLICE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               bin_q, bin_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               sign_q, sign_d, zero_q, zero_d, borrow_q, borrow_d;
  logic               parity_q, parity_d, ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;
  logic [WIDTH+SLICE_W-1:0] acc_cat;
  logic [WIDTH-1:0]   acc_next;

  // Operands shift right each RUN cycle so the active nibble is always [3:0].
  sub4 u_slice (
    .a    (x_q[SLICE_W-1:0]),
    .b    (y_q[SLICE_W-1:0]),
    .bin  (bin_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // New nibble enters at the top; after NIB shifts acc holds the full result.
  assign acc_cat  = {slice_d, acc_q} >> SLICE_W;
  assign acc_next = acc_cat[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    bin_d    = bin_q;
    z_d      = z_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    borrow_d = borrow_q;
    parity_d = parity_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          acc_d   = '0;
          idx_d   = '0;
          bin_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        x_d   = x_q >> SLICE_W;
        y_d   = y_q >> SLICE_W;
        acc_d = acc_next;
        bin_d = slice_bout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          idx_d    = '0;
          z_d      = acc_next;
          sign_d   = acc_next[WIDTH-1];
          zero_d   = (acc_next == '0);
          borrow_d = slice_bout;
          parity_d = ~^acc_next;
          // On the last slice x_q/y_q[3] are the original operand MSBs.
          ovf_d    = (x_q[SLICE_W-1] & ~y_q[SLICE_W-1] & ~acc_next[WIDTH-1]) |
                     (~x_q[SLICE_W-1] & y_q[SLICE_W-1] & acc_next[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      bin_q    <= 1'b0;
      z_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
      parity_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      bin_q    <= bin_d;
      z_q      <= z_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      borrow_q <= borrow_d;
      parity_q <= parity_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.z        = z_q;
  assign bus.sign     = sign_q;
  assign bus.zero     = zero_q;
  assign bus.borrow   = borrow_q;
  assign bus.parity   = parity_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_sub16_seq.sv
// Directed self-checking bench for sub16_seq (WIDTH=16).
module tb_sub16_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sub16_seq_if #(.WIDTH(16)) bus ();

  sub16_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] ez, input logic es,
                          input logic ezr, input logic eb, input logic ep, input logic eo);
    chk({tag, "_z"},        bus.z,        ez);
    chk({tag, "_sign"},     bus.sign,     es);
    chk({tag, "_zero"},     bus.zero,     ezr);
    chk({tag, "_borrow"},   bus.borrow,   eb);
    chk({tag, "_parity"},   bus.parity,   ep);
    chk({tag, "_overflow"}, bus.overflow, eo);
  endtask

  // Accept an operation at the next edge, then scramble the inputs.
  task automatic start_op(input logic [15:0] xv, input logic [15:0] yv);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    tick;
    bus.start = 1'b0;
    bus.x     = ~xv;
    bus.y     = yv ^ 16'h5A5A;
    chk("accept_busy", bus.busy, 1'b1);
    chk("accept_done", bus.done, 1'b0);
  endtask

  // Run the four RUN edges; ends in the DONE cycle.
  task automatic finish_op(input string tag, input logic [15:0] ez, input logic es,
                           input logic ezr, input logic eb, input logic ep, input logic eo,
                           input logic [15:0] prev_z, input logic noise);
    for (int i = 1; i <= 4; i++) begin
      tick;
      if (noise && i == 1) begin
        bus.start = 1'b1;
        bus.x     = 16'h1234;
        bus.y     = 16'h0001;
      end
      if (noise && i == 2) bus.start = 1'b0;
      if (i < 4) begin
        chk({tag, "_run_done"}, bus.done, 1'b0);
        chk({tag, "_run_busy"}, bus.busy, 1'b1);
        chk({tag, "_run_zhold"}, bus.z, prev_z);
      end else begin
        chk({tag, "_done"}, bus.done, 1'b1);
        chk({tag, "_done_busy"}, bus.busy, 1'b0);
        chk_outs(tag, ez, es, ezr, eb, ep, eo);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    rst       = 1'b1;
    tick;
    tick;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk_outs("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start together with rst is ignored
    bus.start = 1'b1;
    bus.x     = 16'h0005;
    bus.y     = 16'h0003;
    tick;
    chk("rst_start_busy", bus.busy, 1'b0);
    rst       = 1'b0;
    bus.start = 1'b0;
    tick;
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_done", bus.done, 1'b0);

    start_op(16'h0005, 16'h0003);
    finish_op("v5m3", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick;
    chk("post_done", bus.done, 1'b0);
    chk("post_busy", bus.busy, 1'b0);
    chk("post_zhold", bus.z, 16'h0002);

    start_op(16'h0003, 16'h0005);
    finish_op("v3m5", 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0);
    tick;

    start_op(16'h8000, 16'h0001);
    finish_op("v8000m1", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    tick;

    start_op(16'h1000, 16'h0001);
    finish_op("v1000m1", 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0);
    tick;

    start_op(16'h1234, 16'h1234);
    finish_op("veq", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0FFF, 1'b0);
    tick;

    // start during RUN ignored, then back-to-back start from DONE
    start_op(16'h0005, 16'h0003);
    finish_op("noise", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    start_op(16'h8000, 16'h0001);
    finish_op("b2b", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
    tick;

    // reset in the 2nd RUN cycle aborts the operation
    start_op(16'h0003, 16'h0005);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk_outs("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("abort_nodone", bus.done, 1'b0);
    end

    start_op(16'h1000, 16'h0001);
    finish_op("after_abort", 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick;
    chk("final_idle_done", bus.done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
